// File: rtl/bit_packer_if.sv
// Stream interface for bit_packer: sparse lane input side and packed word output side.
interface bit_packer_if #(
    parameter int unsigned IN_LANES = 6,
    parameter int unsigned OUT_W    = 16
);
    localparam int unsigned FW = $clog2(OUT_W + 1);

    logic [IN_LANES-1:0] in_valid;
    logic [IN_LANES-1:0] in_bits;
    logic                in_ready;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_word;
    logic [FW-1:0]       out_fill;

    modport master (
        output in_valid, in_bits, flush, out_ready,
        input  in_ready, out_valid, out_word, out_fill
    );

    modport slave (
        input  in_valid, in_bits, flush, out_ready,
        output in_ready, out_valid, out_word, out_fill
    );
endinterface

// File: rtl/bit_packer.sv
// Compacts sparse valid lanes into a bit accumulator and emits OUT_W-bit words.
// Define BIT_PACKER_DROP_CNT_EN to count valid bits lost to a full accumulator.
module bit_packer #(
    parameter int unsigned IN_LANES  = 6,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned ACC_DEPTH = 32,
    parameter int unsigned DROP_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    bit_packer_if.slave       bus,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int unsigned CW        = $clog2(ACC_DEPTH + 1);
    localparam int unsigned FW        = $clog2(OUT_W + 1);
    localparam int unsigned NW        = $clog2(IN_LANES + 1);
    localparam int unsigned READY_MAX = ACC_DEPTH - IN_LANES;

    logic [ACC_DEPTH-1:0] acc;
    logic [ACC_DEPTH-1:0] acc_nxt;
    logic [ACC_DEPTH-1:0] base_acc;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic [CW-1:0]        base_cnt;
    logic [IN_LANES-1:0]  comp;
    logic [NW-1:0]        n_in;
    logic                 in_ready_c;
    logic                 slot_free;
    logic                 do_xfer;
    logic                 do_flush;
    logic                 beat;
    logic                 accept;
    logic                 valid_q;
    logic [OUT_W-1:0]     word_q;
    logic [FW-1:0]        fill_q;

    // Gap removal: walk lanes high to low so lane 0 lands at bit 0
    always_comb begin
        comp = '0;
        n_in = '0;
        for (int i = IN_LANES - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                comp = (comp << 1) | IN_LANES'(bus.in_bits[i]);
                n_in = n_in + NW'(1);
            end
        end
    end

    assign in_ready_c = (count <= CW'(READY_MAX));
    assign slot_free  = !valid_q || bus.out_ready;
    assign do_xfer    = (count >= CW'(OUT_W)) && slot_free;
    assign do_flush   = bus.flush && (count != '0) && (count < CW'(OUT_W)) && slot_free;
    assign beat       = |bus.in_valid;
    assign accept     = beat && in_ready_c;

    // Remove whatever leaves this edge, then append the beat on top of the remainder
    always_comb begin
        base_acc = acc;
        base_cnt = count;
        if (do_xfer) begin
            base_acc = acc >> OUT_W;
            base_cnt = count - CW'(OUT_W);
        end else if (do_flush) begin
            base_acc = '0;
            base_cnt = '0;
        end
        acc_nxt   = base_acc;
        count_nxt = base_cnt;
        if (accept) begin
            acc_nxt   = base_acc | (ACC_DEPTH'(comp) << base_cnt);
            count_nxt = base_cnt + CW'(n_in);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc   <= '0;
            count <= '0;
        end else begin
            acc   <= acc_nxt;
            count <= count_nxt;
        end
    end

    // Output holding register; upper accumulator bits are zero, so a flush pads for free
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            fill_q  <= '0;
        end else if (do_xfer) begin
            valid_q <= 1'b1;
            word_q  <= acc[OUT_W-1:0];
            fill_q  <= FW'(OUT_W);
        end else if (do_flush) begin
            valid_q <= 1'b1;
            word_q  <= acc[OUT_W-1:0];
            fill_q  <= FW'(count);
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_word  = word_q;
    assign bus.out_fill  = fill_q;

`ifdef BIT_PACKER_DROP_CNT_EN
    logic [DROP_W:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(n_in);

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (beat && !in_ready_c) begin
            drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
